// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the unified I/D SRAM arbiter: FSM state and access-owner
// encodings plus the fixed bus widths.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  localparam int DATA_W   = 32;
  localparam int BE_W     = 4;
  localparam int LAT_W    = 2;
  localparam int STARVE_W = 4;

endpackage

// File: rtl/mem_arbiter.sv
// Shares one single-ported SRAM between a read-only fetch port and a byte-enabled
// load/store port. One access in flight; D has priority, I is protected from starvation.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int MEM_LAT      = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              halt,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [BE_W-1:0]   d_we,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [BE_W-1:0]   mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [LAT_W-1:0]    LAT_INIT   = LAT_W'(MEM_LAT - 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  state_t                state;
  state_t                state_nxt;
  owner_t                owner;
  logic [LAT_W-1:0]      lat_cnt;
  logic [STARVE_W-1:0]   starve_cnt;
  logic [ADDR_W-1:0]     cmd_addr;
  logic [BE_W-1:0]       cmd_we;
  logic [DATA_W-1:0]     cmd_wdata;
  logic [DATA_W-1:0]     i_rdata_q;
  logic [DATA_W-1:0]     d_rdata_q;
  logic                  decide;
  logic                  grant;
  logic                  conflict;
  logic                  win_d;
  logic                  first_cmd;
  logic                  last_cmd;

  // rst gates the decision so the Mealy acks stay low while reset is held
  assign decide    = rst && !halt && (state == IDLE || state == RESP);
  assign grant     = decide && (i_req || d_req);
  assign conflict  = i_req && d_req;
  assign win_d     = d_req && !(i_req && starve_cnt == STARVE_MAX);
  assign first_cmd = (state == CMD) && (lat_cnt == LAT_INIT);
  assign last_cmd  = (state == CMD) && (lat_cnt == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, RESP: state_nxt = grant ? CMD : IDLE;
      CMD:        if (lat_cnt == '0) state_nxt = RESP;
      default:    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    i_ack    = 1'b0;
    d_ack    = 1'b0;
    i_rvalid = 1'b0;
    d_rvalid = 1'b0;
    mem_we   = '0;
    if (grant) begin
      d_ack = win_d;
      i_ack = !win_d;
    end
    if (state == RESP) begin
      i_rvalid = (owner == OWN_I);
      d_rvalid = (owner == OWN_D);
    end
    // the write strobe is issued once even though the address is held MEM_LAT cycles
    if (first_cmd) mem_we = cmd_we;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner     <= OWN_I;
      lat_cnt   <= '0;
      cmd_addr  <= '0;
      cmd_we    <= '0;
      cmd_wdata <= '0;
    end else if (grant) begin
      owner     <= win_d ? OWN_D : OWN_I;
      lat_cnt   <= LAT_INIT;
      cmd_addr  <= win_d ? d_addr : i_addr;
      cmd_we    <= win_d ? d_we : '0;
      cmd_wdata <= win_d ? d_wdata : '0;
    end else if (state == CMD && lat_cnt != '0) begin
      lat_cnt <= lat_cnt - LAT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else if (last_cmd) begin
      if (owner == OWN_D) d_rdata_q <= (cmd_we != '0) ? '0 : mem_rdata;
      else                i_rdata_q <= mem_rdata;
    end
  end

  // counts conflicts lost by I; an I grant of any kind clears it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (grant) begin
      if (!win_d)
        starve_cnt <= '0;
      else if (conflict && starve_cnt != STARVE_MAX)
        starve_cnt <= starve_cnt + STARVE_W'(1);
    end
  end

  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign mem_addr  = cmd_addr;
  assign mem_wdata = cmd_wdata;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic, every cycle checked
// against a transaction-level model of grants, timing, SRAM contents and starvation.
module tb_mem_arbiter;

  localparam int ADDR_W       = 32;
  localparam int MEM_LAT      = 2;
  localparam int STARVE_LIMIT = 4;

  logic              clk  = 1'b0;
  logic              rst  = 1'b0;
  logic              halt = 1'b0;
  logic              i_req = 1'b0;
  logic [ADDR_W-1:0] i_addr = '0;
  logic              i_ack, i_rvalid;
  logic [31:0]       i_rdata;
  logic              d_req = 1'b0;
  logic [ADDR_W-1:0] d_addr = '0;
  logic [3:0]        d_we = '0;
  logic [31:0]       d_wdata = '0;
  logic              d_ack, d_rvalid;
  logic [31:0]       d_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_we;
  logic [31:0]       mem_wdata, mem_rdata;
  logic              busy;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(ADDR_W), .MEM_LAT(MEM_LAT), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .rst(rst), .halt(halt),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  function automatic logic [31:0] init_word(input int k);
    return 32'hC0DE_0000 ^ (k * 32'h0001_0203);
  endfunction

  // SRAM: asynchronous read, byte-masked write on the clock edge
  logic [31:0] sram [64];
  assign mem_rdata = sram[mem_addr[7:2]];
  initial begin
    for (int k = 0; k < 64; k++) sram[k] = init_word(k);
    forever begin
      @(posedge clk);
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) sram[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Reference model: an access acked at cycle A drives the SRAM during A+1..A+MEM_LAT
  // and reports at A+MEM_LAT+1, which is also the next cycle a grant may be made.
  int          ack_at = -10;
  int          resp_at = -1;
  int          starve = 0;
  bit          m_own_d;
  logic [3:0]  m_we;
  logic [31:0] m_data;
  logic [31:0] x_irdata = '0, x_drdata = '0, x_addr = '0, x_wdata = '0;
  logic [31:0] ref_mem [64];
  bit          seen_i_ack, seen_d_ack, seen_i_rv, seen_d_rv;
  bit          grants[$];
  bit          free, grant, win_d, e_busy;
  logic [3:0]  e_we;

  initial begin
    for (int k = 0; k < 64; k++) ref_mem[k] = init_word(k);
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        ack_at = -10; resp_at = -1; starve = 0;
        x_irdata = '0; x_drdata = '0; x_addr = '0; x_wdata = '0;
        chk("rst_flags", {27'd0, i_ack, d_ack, i_rvalid, d_rvalid, busy}, 32'd0);
        chk("rst_mem_we", {28'd0, mem_we}, 32'd0);
        chk("rst_i_rdata", i_rdata, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
      end else begin
        free   = (resp_at < 0) || (cyc >= resp_at);
        e_busy = (resp_at >= 0) && (cyc > ack_at) && (cyc <= resp_at);
        e_we   = (resp_at >= 0 && cyc == ack_at + 1) ? m_we : 4'h0;
        if (cyc == resp_at) begin
          if (m_own_d) x_drdata = m_data;
          else         x_irdata = m_data;
        end
        if (resp_at >= 0 && cyc == ack_at + 1)
          for (int b = 0; b < 4; b++)
            if (m_we[b]) ref_mem[x_addr[7:2]][8*b +: 8] = x_wdata[8*b +: 8];
        grant = free && !halt && (i_req || d_req);
        win_d = d_req && (!i_req || starve != STARVE_LIMIT);
        chk("i_ack", {31'd0, i_ack}, {31'd0, grant && !win_d});
        chk("d_ack", {31'd0, d_ack}, {31'd0, grant && win_d});
        chk("i_rvalid", {31'd0, i_rvalid}, {31'd0, cyc == resp_at && !m_own_d});
        chk("d_rvalid", {31'd0, d_rvalid}, {31'd0, cyc == resp_at && m_own_d});
        chk("i_rdata", i_rdata, x_irdata);
        chk("d_rdata", d_rdata, x_drdata);
        chk("mem_addr", mem_addr, x_addr);
        chk("mem_wdata", mem_wdata, x_wdata);
        chk("mem_we", {28'd0, mem_we}, {28'd0, e_we});
        chk("busy", {31'd0, busy}, {31'd0, e_busy});
        if (grant) begin
          if (!win_d) starve = 0;
          else if (i_req && starve < STARVE_LIMIT) starve++;
          m_own_d = win_d;
          ack_at  = cyc;
          resp_at = cyc + MEM_LAT + 1;
          if (win_d) begin
            m_we = d_we; x_addr = d_addr; x_wdata = d_wdata;
            m_data = (d_we == 4'h0) ? ref_mem[d_addr[7:2]] : 32'd0;
          end else begin
            m_we = 4'h0; x_addr = i_addr; x_wdata = 32'd0;
            m_data = ref_mem[i_addr[7:2]];
          end
        end
      end
      chk("one_ack", {31'd0, i_ack & d_ack}, 32'd0);
      if (i_ack) grants.push_back(1'b0);
      if (d_ack) grants.push_back(1'b1);
      seen_i_ack = i_ack; seen_d_ack = d_ack;
      seen_i_rv  = i_rvalid; seen_d_rv = d_rvalid;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive_d(input logic [31:0] a, input logic [3:0] we, input logic [31:0] wd);
    d_req = 1'b1; d_addr = a; d_we = we; d_wdata = wd;
  endtask

  // returns in the cycle after the ack with the request dropped
  task automatic wait_ack(input bit is_d, input int max);
    int n;
    for (n = 0; n < max; n++) begin
      @(negedge clk); #1;
      if (is_d ? seen_d_ack : seen_i_ack) break;
      @(posedge clk); #1;
    end
    chk("ack_wait", {31'd0, n < max}, 32'd1);
    if (n < max) begin @(posedge clk); #1; end
    if (is_d) d_req = 1'b0;
    else      i_req = 1'b0;
  endtask

  // returns just after the falling edge of the rvalid cycle
  task automatic wait_rv(input bit is_d, input int max);
    int n;
    for (n = 0; n < max; n++) begin
      @(negedge clk); #1;
      if (is_d ? seen_d_rv : seen_i_rv) break;
      @(posedge clk); #1;
    end
    chk("rv_wait", {31'd0, n < max}, 32'd1);
  endtask

  logic [5:0] order;
  bit         drop_i;

  initial begin
    // reset held with a pending data request, then released
    rst = 1'b0;
    drive_d(32'h40, 4'h0, 32'h0);
    repeat (3) tick();
    rst = 1'b1;
    @(negedge clk); #1;
    chk("rst_release_ack", {31'd0, seen_d_ack}, 32'd1);
    tick();
    d_req = 1'b0;
    wait_rv(1'b1, 10);
    tick();

    // store then fetch the same word
    drive_d(32'h10, 4'hF, 32'hDEADBEEF);
    wait_ack(1'b1, 10);
    wait_rv(1'b1, 10);
    tick();
    i_req = 1'b1; i_addr = 32'h10;
    wait_ack(1'b0, 10);
    wait_rv(1'b0, 10);
    chk("fetch_data", i_rdata, 32'hDEADBEEF);
    tick();

    // partial store: strobe only in the first command cycle, zero load data
    drive_d(32'h40, 4'b0011, 32'h1234ABCD);
    wait_ack(1'b1, 10);
    wait_rv(1'b1, 10);
    chk("store_rdata", d_rdata, 32'd0);
    tick();
    d_req = 1'b1; d_addr = 32'h40; d_we = 4'h0;
    wait_ack(1'b1, 10);
    wait_rv(1'b1, 10);
    chk("store_readback", d_rdata, init_word(16) & 32'hFFFF_0000 | 32'h0000_ABCD);
    tick();

    // sustained conflict from a clean starvation count
    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    grants.delete();
    i_req = 1'b1; i_addr = 32'h80;
    drive_d(32'h84, 4'h0, 32'h0);
    for (int c = 0; c < 80 && grants.size() < 6; c++) begin
      @(negedge clk); #1;
      drop_i = seen_i_ack;
      @(posedge clk); #1;
      if (drop_i) i_req = 1'b0;
    end
    d_req = 1'b0; i_req = 1'b0;
    order = '0;
    for (int k = 0; k < 6; k++)
      if (k < grants.size()) order = {order[4:0], grants[k]};
    chk("grant_order", {26'd0, order}, {26'd0, 6'b111101});
    repeat (MEM_LAT + 2) tick();

    // fetch pending through a load: granted in the load's response cycle
    drive_d(32'h24, 4'h0, 32'h0);
    wait_ack(1'b1, 10);
    i_req = 1'b1; i_addr = 32'h28;
    wait_rv(1'b1, 10);
    chk("b2b_i_ack_in_resp", {31'd0, seen_i_ack}, 32'd1);
    tick();
    i_req = 1'b0;
    wait_rv(1'b0, 10);
    tick();

    // halt during a command: response still arrives, no new grant
    drive_d(32'h30, 4'h0, 32'h0);
    wait_ack(1'b1, 10);
    halt = 1'b1; i_req = 1'b1; i_addr = 32'h34;
    wait_rv(1'b1, 10);
    chk("halt_no_ack", {31'd0, seen_i_ack}, 32'd0);
    tick();
    repeat (2) begin
      @(negedge clk); #1;
      chk("halt_hold", {31'd0, seen_i_ack}, 32'd0);
      tick();
    end
    halt = 1'b0;
    wait_ack(1'b0, 10);
    wait_rv(1'b0, 10);
    tick();

    // reset during a command aborts it; the request is re-acked after release
    drive_d(32'h38, 4'h0, 32'h0);
    wait_ack(1'b1, 10);
    rst = 1'b0;
    d_req = 1'b1;
    @(negedge clk); #1;
    chk("rst_abort_busy", {31'd0, busy}, 32'd0);
    tick();
    tick();
    rst = 1'b1;
    wait_ack(1'b1, 2);
    wait_rv(1'b1, 10);
    tick();

    // randomized traffic with drops, halts and short reset pulses
    for (int c = 0; c < 3000; c++) begin
      if (seen_i_ack) i_req = 1'b0;
      if (seen_d_ack) d_req = 1'b0;
      if (!i_req && $urandom_range(0, 2) == 0) begin
        i_req = 1'b1; i_addr = $urandom;
      end else if (i_req && $urandom_range(0, 15) == 0) begin
        i_req = 1'b0;
      end
      if (!d_req && $urandom_range(0, 1) == 0) begin
        d_req = 1'b1; d_addr = $urandom; d_wdata = $urandom;
        d_we = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      end else if (d_req && $urandom_range(0, 15) == 0) begin
        d_req = 1'b0;
      end
      halt = ($urandom_range(0, 7) == 0);
      rst  = ($urandom_range(0, 199) != 0);
      tick();
    end
    i_req = 1'b0; d_req = 1'b0; halt = 1'b0; rst = 1'b1;
    repeat (MEM_LAT + 3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-ported SRAM between the instruction-fetch port (I, read-only) and the load/store port (D, read/write with byte enables).
- Sits between the core and a unified instruction/data SRAM, replacing separate IM/DM instances.
- Uses a request/ack/rvalid handshake with one access in flight.
- D has priority; a starvation counter guarantees forward progress for fetch.

Parameters:
ADDR_W, 32, width of all address buses
MEM_LAT, 1, SRAM read latency in cycles (legal 1..4); each access holds the SRAM command for MEM_LAT cycles
STARVE_LIMIT, 4, consecutive lost conflicts after which I wins the next conflict (legal 1..15)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
halt  in  1  when high, no new grants; in-flight access completes
i_req  in  1  fetch request, held until i_ack
i_addr  in  ADDR_W  fetch address
i_ack  out  1  one-cycle pulse: fetch accepted this cycle
i_rvalid  out  1  one-cycle pulse: i_rdata valid
i_rdata  out  32  fetched word
d_req  in  1  data request, held until d_ack
d_addr  in  ADDR_W  data address
d_we  in  4  byte write enables (0 = read)
d_wdata  in  32  store data
d_ack  out  1  one-cycle pulse: data access accepted
d_rvalid  out  1  one-cycle pulse: load data valid, or store complete
d_rdata  out  32  load word; 0 for stores
mem_addr  out  ADDR_W  SRAM address
mem_we  out  4  SRAM byte write enables
mem_wdata  out  32  SRAM write data
mem_rdata  in  32  SRAM read data
busy  out  1  access in flight (state != IDLE)

Behaviour:
Reset:
- While rst is low, state = IDLE and all outputs, the starvation count and the latency count are 0.
- Assertion mid-access aborts it: no rvalid is issued, and the requester must re-request.

States: IDLE, CMD, RESP.

IDLE:
- A grant occurs when halt = 0 and at least one request is high.
- Arbitration:
  - Only one requester high: that requester wins.
  - Both high: D wins, unless starve_cnt == STARVE_LIMIT, in which case I wins.
- The ack to the winner is combinational in the same cycle (Mealy).
- On the clock edge: the winner's address/we/wdata are registered and the state goes to CMD with lat_cnt = MEM_LAT-1.

CMD:
- mem_addr and mem_wdata are held stable from the registered command for MEM_LAT cycles.
- mem_we equals the registered we in the first CMD cycle only, and is 0 in later cycles.
- lat_cnt decrements each cycle.
- At lat_cnt == 0: capture mem_rdata (or 0 if the access was a write) into the owner's rdata register, then go to RESP.

RESP:
- The owner's rvalid is high for exactly one cycle. The rdata registers hold their value until the next capture.
- RESP acts as IDLE in the same cycle: it may ack a new request, then goes to CMD or IDLE.
- Timing:
  - Ack at cycle T; command at T+1..T+MEM_LAT; rvalid at T+MEM_LAT+1.
  - Peak throughput is one access per MEM_LAT+1 cycles.

Starvation counter (4 bits):
- Increments when a grant decision has both requests high and D wins.
- Clears when I is granted.
- Saturates at STARVE_LIMIT.

Other rules:
- Acks are never asserted outside IDLE/RESP decision cycles, and never to both ports in one cycle.
- When idle, mem_we = 0; mem_addr and mem_wdata hold their last value.
- Requests dropped before ack are ignored. Requests changing after ack do not affect the in-flight access.
- halt high in IDLE/RESP blocks the grant but not rvalid.

Decomposition:
- Shared definitions header (alongside existing opcode defines):
  - state encoding: IDLE=2'd0, CMD=2'd1, RESP=2'd2
  - owner encoding: OWN_I=1'b0, OWN_D=1'b1
- The grant decision and starvation counter are small enough to stay inline; no sub-module is required.

Test Plan:
1. Reset: hold rst=0 with d_req=1 → all outputs 0. Release rst → d_ack in the first cycle.
2. I-only read, MEM_LAT=1, i_addr=0x10, SRAM word 0xDEADBEEF:
   - i_ack at T
   - mem_addr=0x10, mem_we=0 at T+1
   - i_rvalid=1, i_rdata=0xDEADBEEF at T+2
3. Store, MEM_LAT=2, d_addr=0x40, d_we=4'b0011, d_wdata=0x1234ABCD:
   - mem_we=0011 at T+1 only, 0 at T+2
   - d_rvalid at T+3 with d_rdata=0
4. Conflict, STARVE_LIMIT=4: i_req and d_req held high continuously, d_req re-raised after each d_rvalid → grant order D,D,D,D,I,D…; starve_cnt returns to 0 after the I grant.
5. Back-to-back, MEM_LAT=1: both requests pending in the RESP cycle of a D read → I acked in that same RESP cycle, i_rvalid two cycles later; no cycle with both acks.
6. Mid-access disturbances:
   - halt=1 during CMD: current rvalid still occurs; no ack while halt=1.
   - rst=0 during CMD: no rvalid; state IDLE; the request is re-acked after release.
